// File: rtl/wbx_arbiter.sv
// rtl/wbx_arbiter.sv - round-robin Wishbone multi-master to multi-slave arbiter; optional BUSY timeout via WBX_TIMEOUT_EN
module wbx_arbiter #(
  parameter int MASTER_NUM     = 2,
  parameter int PERIPH_NUM     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [MASTER_NUM-1:0]    wbm_stb_i,
  input  logic [MASTER_NUM-1:0]    wbm_we_i,
  input  logic [16*MASTER_NUM-1:0] wbm_adr_i,
  input  logic [32*MASTER_NUM-1:0] wbm_dat_i,
  output logic [31:0]              wbm_dat_o,
  output logic [MASTER_NUM-1:0]    wbm_ack_o,
  output logic [MASTER_NUM-1:0]    wbm_err_o,
  output logic [PERIPH_NUM-1:0]    wbs_stb_o,
  output logic                     wbs_we_o,
  output logic [3:0]               wbs_adr_o,
  output logic [31:0]              wbs_dat_o,
  input  logic [32*PERIPH_NUM-1:0] wbs_dat_i,
  input  logic [PERIPH_NUM-1:0]    wbs_ack_i
);

  localparam int MW = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [MW-1:0]   r_grant;
  logic [MW-1:0]   r_last;
  logic            r_we;
  logic [15:0]     r_adr;
  logic [31:0]     r_dat;

  logic            w_any;
  logic [MW-1:0]   w_pick;
  logic            w_cap_we;
  logic [15:0]     w_cap_adr;
  logic [31:0]     w_cap_dat;
  logic [11:0]     w_idx;
  logic            w_mapped;
  logic            w_gstb;
  logic            w_ack;
  logic [31:0]     w_rdata;
  logic            w_err;
  logic            w_tmo_hit;

  // First requester strictly after the last granted index, wrapping around.
  function automatic logic [MW-1:0] rr_pick(input logic [MW-1:0] last,
                                            input logic [MASTER_NUM-1:0] req);
    logic [MW-1:0]         pick;
    logic                  found;
    logic [MASTER_NUM-1:0] sh;
    int                    c;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= MASTER_NUM; k++) begin
      c  = (int'(last) + k) % MASTER_NUM;
      sh = req >> c;
      if (!found && sh[0]) begin
        pick  = MW'(c);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign w_any    = |wbm_stb_i;
  assign w_pick   = rr_pick(r_last, wbm_stb_i);
  assign w_idx    = r_adr[15:4];
  assign w_mapped = (w_idx < 12'(PERIPH_NUM));

  // Select the winning master's request fields for capture at grant time.
  always_comb begin
    w_cap_we  = 1'b0;
    w_cap_adr = 16'h0000;
    w_cap_dat = 32'h0000_0000;
    for (int m = 0; m < MASTER_NUM; m++) begin
      if (w_pick == MW'(m)) begin
        w_cap_we  = wbm_we_i[m];
        w_cap_adr = wbm_adr_i[16*m +: 16];
        w_cap_dat = wbm_dat_i[32*m +: 32];
      end
    end
  end

  // Strobe of the currently granted master, used to detect an abort.
  always_comb begin
    w_gstb = 1'b0;
    for (int m = 0; m < MASTER_NUM; m++) begin
      if (r_grant == MW'(m)) begin
        w_gstb = wbm_stb_i[m];
      end
    end
  end

  // Ack and read data come only from the decoded slave; others are ignored.
  always_comb begin
    w_ack   = 1'b0;
    w_rdata = 32'h0000_0000;
    if (r_state == S_BUSY) begin
      for (int p = 0; p < PERIPH_NUM; p++) begin
        if ((w_idx == 12'(p)) && wbs_ack_i[p]) begin
          w_ack   = 1'b1;
          w_rdata = wbs_dat_i[32*p +: 32];
        end
      end
    end
  end

`ifdef WBX_TIMEOUT_EN
  logic [15:0] r_tmo;

  // Count BUSY cycles from 0; restart whenever the arbiter is idle.
  always_ff @(posedge clk) begin
    if (rst || (r_state == S_IDLE)) begin
      r_tmo <= 16'h0000;
    end else begin
      r_tmo <= r_tmo + 16'd1;
    end
  end

  assign w_tmo_hit = (r_state == S_BUSY) && (r_tmo == 16'(TIMEOUT_CYCLES));
`else
  logic w_unused_tmo;
  assign w_tmo_hit    = 1'b0;
  assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
`endif

  // Error only while the master still holds its request; ack takes precedence.
  assign w_err = (r_state == S_BUSY) && !w_ack && w_gstb && (!w_mapped || w_tmo_hit);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: ack wins over abort; abort wins over error.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_ack || !w_gstb || w_err) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grant/request capture and round-robin pointer update on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant <= '0;
      r_last  <= MW'(MASTER_NUM - 1);
      r_we    <= 1'b0;
      r_adr   <= 16'h0000;
      r_dat   <= 32'h0000_0000;
    end else begin
      if ((r_state == S_IDLE) && w_any) begin
        r_grant <= w_pick;
        r_we    <= w_cap_we;
        r_adr   <= w_cap_adr;
        r_dat   <= w_cap_dat;
      end
      if ((r_state == S_BUSY) && (w_state_nxt == S_IDLE)) begin
        r_last <= r_grant;
      end
    end
  end

  // Output decode: slave strobe while BUSY to a mapped slave, master ack/err steered by grant.
  always_comb begin
    wbs_stb_o = '0;
    wbm_ack_o = '0;
    wbm_err_o = '0;
    wbm_dat_o = 32'h0000_0000;
    if ((r_state == S_BUSY) && w_mapped) begin
      for (int p = 0; p < PERIPH_NUM; p++) begin
        wbs_stb_o[p] = (w_idx == 12'(p));
      end
    end
    for (int m = 0; m < MASTER_NUM; m++) begin
      if (r_grant == MW'(m)) begin
        wbm_ack_o[m] = w_ack;
        wbm_err_o[m] = w_err;
      end
    end
    if (w_ack) begin
      wbm_dat_o = w_rdata;
    end
  end

  assign wbs_we_o  = r_we;
  assign wbs_adr_o = r_adr[3:0];
  assign wbs_dat_o = r_dat;

endmodule

// File: tb/tb_wbx_arbiter.sv
// tb/tb_wbx_arbiter.sv - self-checking bench for wbx_arbiter (MASTER_NUM=2, PERIPH_NUM=4)
module tb_wbx_arbiter;

  localparam int TMO = 255;

  logic         clk;
  logic         rst;
  logic [1:0]   wbm_stb_i;
  logic [1:0]   wbm_we_i;
  logic [31:0]  wbm_adr_i;
  logic [63:0]  wbm_dat_i;
  logic [31:0]  wbm_dat_o;
  logic [1:0]   wbm_ack_o;
  logic [1:0]   wbm_err_o;
  logic [3:0]   wbs_stb_o;
  logic         wbs_we_o;
  logic [3:0]   wbs_adr_o;
  logic [31:0]  wbs_dat_o;
  logic [127:0] wbs_dat_i;
  logic [3:0]   wbs_ack_i;
  logic [3:0]   man_ack;
  logic         auto_ack;

  int checks;
  int failures;

  typedef struct {
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [31:0] dat;
  } exp_t;

  exp_t exp_q[$];

  assign wbs_ack_i = auto_ack ? wbs_stb_o : man_ack;

  wbx_arbiter #(
    .MASTER_NUM    (2),
    .PERIPH_NUM    (4),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wbm_stb_i(wbm_stb_i),
    .wbm_we_i (wbm_we_i),
    .wbm_adr_i(wbm_adr_i),
    .wbm_dat_i(wbm_dat_i),
    .wbm_dat_o(wbm_dat_o),
    .wbm_ack_o(wbm_ack_o),
    .wbm_err_o(wbm_err_o),
    .wbs_stb_o(wbs_stb_o),
    .wbs_we_o (wbs_we_o),
    .wbs_adr_o(wbs_adr_o),
    .wbs_dat_o(wbs_dat_o),
    .wbs_dat_i(wbs_dat_i),
    .wbs_ack_i(wbs_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every ack/err seen on the master side must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && ((|wbm_ack_o) || (|wbm_err_o))) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected ack=%b err=%b dat=%h", wbm_ack_o, wbm_err_o, wbm_dat_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({wbm_ack_o, wbm_err_o, wbm_dat_o} !== {e.ack, e.err, e.dat}) begin
          failures++;
          $display("FAIL sb_event got ack=%b err=%b dat=%h exp ack=%b err=%b dat=%h",
                   wbm_ack_o, wbm_err_o, wbm_dat_o, e.ack, e.err, e.dat);
        end
      end
    end else if (!rst) begin
      checks++;
      if (wbm_dat_o !== 32'h0) begin
        failures++;
        $display("FAIL dat_no_ack got=%h exp=00000000", wbm_dat_o);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] a, input logic [1:0] e, input logic [31:0] d);
    exp_t x;
    x.ack = a;
    x.err = e;
    x.dat = d;
    exp_q.push_back(x);
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    wbm_stb_i = 2'b00;
    man_ack   = 4'b0000;
    auto_ack  = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    wbm_stb_i = 2'b00;
    man_ack   = 4'b0000;
    auto_ack  = 1'b0;
    cyc();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_dat_o} !== 40'h0) begin
        failures++;
        $display("FAIL reset_outputs stb=%b ack=%b err=%b dat=%h exp all 0",
                 wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_dat_o);
      end
      cyc();
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({wbs_stb_o, wbm_ack_o, wbm_err_o} !== 8'h0) begin
      failures++;
      $display("FAIL reset_after stb=%b ack=%b err=%b exp all 0", wbs_stb_o, wbm_ack_o, wbm_err_o);
    end
    cyc();
  endtask

  task automatic test_write();
    apply_reset();
    wbm_stb_i        = 2'b01;
    wbm_we_i         = 2'b01;
    wbm_adr_i[15:0]  = 16'h0012;
    wbm_dat_i[31:0]  = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (wbs_stb_o !== 4'b0000) begin
      failures++;
      $display("FAIL write_idle_stb got=%b exp=0000", wbs_stb_o);
    end
    cyc();
    @(negedge clk);
    checks++;
    if ({wbs_stb_o, wbs_adr_o, wbs_we_o, wbs_dat_o, wbm_ack_o} !==
        {4'b0010, 4'h2, 1'b1, 32'hDEADBEEF, 2'b00}) begin
      failures++;
      $display("FAIL write_fwd got stb=%b adr=%h we=%b dat=%h ack=%b exp 0010 2 1 deadbeef 00",
               wbs_stb_o, wbs_adr_o, wbs_we_o, wbs_dat_o, wbm_ack_o);
    end
    cyc();
    man_ack = 4'b0100;
    @(negedge clk);
    checks++;
    if ({wbm_ack_o, wbm_dat_o} !== {2'b00, 32'h0}) begin
      failures++;
      $display("FAIL write_foreign_ack got ack=%b dat=%h exp 00 00000000", wbm_ack_o, wbm_dat_o);
    end
    cyc();
    man_ack = 4'b0010;
    push(2'b01, 2'b00, 32'hB1B1B1B1);
    @(negedge clk);
    checks++;
    if ({wbs_stb_o, wbm_ack_o} !== {4'b0010, 2'b01}) begin
      failures++;
      $display("FAIL write_ack got stb=%b ack=%b exp 0010 01", wbs_stb_o, wbm_ack_o);
    end
    cyc();
    wbm_stb_i = 2'b00;
    man_ack   = 4'b0000;
    @(negedge clk);
    checks++;
    if (wbs_stb_o !== 4'b0000) begin
      failures++;
      $display("FAIL write_done_stb got=%b exp=0000", wbs_stb_o);
    end
    cyc();
  endtask

  task automatic test_round_robin();
    logic [5:0] exp_v;
    apply_reset();
    wbm_we_i         = 2'b00;
    wbm_adr_i        = {16'h0020, 16'h0010};
    wbm_stb_i        = 2'b11;
    auto_ack         = 1'b1;
    push(2'b01, 2'b00, 32'hB1B1B1B1);
    push(2'b10, 2'b00, 32'hC2C2C2C2);
    push(2'b01, 2'b00, 32'hB1B1B1B1);
    push(2'b10, 2'b00, 32'hC2C2C2C2);
    for (int c = 0; c < 8; c++) begin
      if ((c % 2) == 0)      exp_v = {4'b0000, 2'b00};
      else if ((c % 4) == 1) exp_v = {4'b0010, 2'b01};
      else                   exp_v = {4'b0100, 2'b10};
      @(negedge clk);
      checks++;
      if ({wbs_stb_o, wbm_ack_o} !== exp_v) begin
        failures++;
        $display("FAIL rr_cycle%0d got stb=%b ack=%b exp stb=%b ack=%b",
                 c, wbs_stb_o, wbm_ack_o, exp_v[5:2], exp_v[1:0]);
      end
      cyc();
    end
    wbm_stb_i = 2'b00;
    auto_ack  = 1'b0;
    cyc();
  endtask

  task automatic test_unmapped();
    wbm_we_i          = 2'b00;
    wbm_adr_i[31:16]  = 16'h0050;
    wbm_stb_i         = 2'b10;
    push(2'b00, 2'b10, 32'h0);
    @(negedge clk);
    checks++;
    if (wbm_err_o !== 2'b00) begin
      failures++;
      $display("FAIL unmapped_early got err=%b exp=00", wbm_err_o);
    end
    cyc();
    @(negedge clk);
    checks++;
    if ({wbs_stb_o, wbm_err_o} !== {4'b0000, 2'b10}) begin
      failures++;
      $display("FAIL unmapped_err got stb=%b err=%b exp 0000 10", wbs_stb_o, wbm_err_o);
    end
    cyc();
    wbm_stb_i = 2'b00;
    @(negedge clk);
    checks++;
    if ({wbs_stb_o, wbm_err_o} !== 6'b0) begin
      failures++;
      $display("FAIL unmapped_after got stb=%b err=%b exp 0000 00", wbs_stb_o, wbm_err_o);
    end
    cyc();
  endtask

  task automatic test_abort();
    apply_reset();
    wbm_adr_i = {16'h0030, 16'h0010};
    wbm_stb_i = 2'b11;
    cyc();
    man_ack = 4'b0001;
    @(negedge clk);
    checks++;
    if ({wbs_stb_o, wbm_ack_o} !== {4'b0010, 2'b00}) begin
      failures++;
      $display("FAIL abort_busy got stb=%b ack=%b exp 0010 00", wbs_stb_o, wbm_ack_o);
    end
    cyc();
    man_ack   = 4'b0000;
    wbm_stb_i = 2'b10;
    cyc();
    @(negedge clk);
    checks++;
    if ({wbs_stb_o, wbm_ack_o, wbm_err_o} !== 8'h0) begin
      failures++;
      $display("FAIL abort_drop got stb=%b ack=%b err=%b exp all 0", wbs_stb_o, wbm_ack_o, wbm_err_o);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (wbs_stb_o !== 4'b1000) begin
      failures++;
      $display("FAIL abort_next_grant got stb=%b exp=1000", wbs_stb_o);
    end
    cyc();
    man_ack = 4'b1000;
    push(2'b10, 2'b00, 32'hD3D3D3D3);
    @(negedge clk);
    checks++;
    if (wbm_ack_o !== 2'b10) begin
      failures++;
      $display("FAIL abort_m1_ack got=%b exp=10", wbm_ack_o);
    end
    cyc();
    wbm_stb_i = 2'b00;
    man_ack   = 4'b0000;
    cyc();
    // Ack arriving in the same cycle the master drops its strobe must still be delivered.
    wbm_stb_i = 2'b01;
    cyc();
    wbm_stb_i = 2'b00;
    man_ack   = 4'b0010;
    push(2'b01, 2'b00, 32'hB1B1B1B1);
    @(negedge clk);
    checks++;
    if (wbm_ack_o !== 2'b01) begin
      failures++;
      $display("FAIL ack_vs_abort got=%b exp=01", wbm_ack_o);
    end
    cyc();
    man_ack = 4'b0000;
    cyc();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    wbm_adr_i = {16'h0020, 16'h0010};
    wbm_stb_i = 2'b11;
    cyc();
    @(negedge clk);
    checks++;
    if (wbs_stb_o !== 4'b0010) begin
      failures++;
      $display("FAIL rstmid_busy got stb=%b exp=0010", wbs_stb_o);
    end
    cyc();
    rst = 1'b1;
    cyc();
    rst     = 1'b0;
    man_ack = 4'b0010;
    @(negedge clk);
    checks++;
    if ({wbs_stb_o, wbm_ack_o, wbm_err_o} !== 8'h0) begin
      failures++;
      $display("FAIL rstmid_dropped got stb=%b ack=%b err=%b exp all 0", wbs_stb_o, wbm_ack_o, wbm_err_o);
    end
    cyc();
    man_ack = 4'b0000;
    @(negedge clk);
    checks++;
    if (wbs_stb_o !== 4'b0010) begin
      failures++;
      $display("FAIL rstmid_m0_first got stb=%b exp=0010", wbs_stb_o);
    end
    cyc();
    man_ack = 4'b0010;
    push(2'b01, 2'b00, 32'hB1B1B1B1);
    @(negedge clk);
    checks++;
    if (wbm_ack_o !== 2'b01) begin
      failures++;
      $display("FAIL rstmid_ack got=%b exp=01", wbm_ack_o);
    end
    cyc();
    wbm_stb_i = 2'b00;
    man_ack   = 4'b0000;
    cyc();
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    apply_reset();
    wbm_adr_i[15:0] = 16'h0010;
    wbm_stb_i       = 2'b01;
    cyc();
`ifdef WBX_TIMEOUT_EN
    push(2'b00, 2'b01, 32'h0);
    for (int k = 0; k <= TMO; k++) begin
      @(negedge clk);
      if (wbs_stb_o !== 4'b0010) bad++;
      if (wbm_err_o !== ((k == TMO) ? 2'b01 : 2'b00)) bad++;
      cyc();
    end
    wbm_stb_i = 2'b00;
    @(negedge clk);
    checks++;
    if (wbs_stb_o !== 4'b0000) begin
      failures++;
      $display("FAIL timeout_stb_drop got=%b exp=0000", wbs_stb_o);
    end
`else
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if ({wbs_stb_o, wbm_ack_o, wbm_err_o} !== {4'b0010, 2'b00, 2'b00}) bad++;
      cyc();
    end
    wbm_stb_i = 2'b00;
`endif
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL timeout_busy_window bad_cycles=%0d exp=0", bad);
    end
    cyc();
    cyc();
    @(negedge clk);
    checks++;
    if (wbs_stb_o !== 4'b0000) begin
      failures++;
      $display("FAIL timeout_final_idle got=%b exp=0000", wbs_stb_o);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    wbm_stb_i = 2'b00;
    wbm_we_i  = 2'b00;
    wbm_adr_i = 32'h0;
    wbm_dat_i = 64'h0;
    man_ack   = 4'b0000;
    auto_ack  = 1'b0;
    wbs_dat_i = {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
    test_reset();
    test_write();
    test_round_robin();
    test_unmapped();
    test_abort();
    test_reset_mid();
    test_timeout();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL sb_leftover pending=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
